// File: rtl/pattern_rx.sv
// ---------------------------------------------------------------------------
// pattern_rx
//
// Serial sync-word receiver. Bits arrive MSB first on D, one per rising CLK
// with EN high. In HUNT the receiver checks every new 16-bit window against
// the reference word N. Once the window matches it enters LOCK and from then
// on checks only at 16-bit word boundaries. MAXERR consecutive bad words
// return the receiver to HUNT.
//
// Optional feature (compile-time macro):
//   PATTERN_RX_ERRCNT_EN  - when defined, ERRCNT is a saturating count of ERR
//                           pulses. Otherwise ERRCNT is tied to 8'h00 and no
//                           counter logic is built.
//
// Parameters:
//   N       - 16-bit reference/sync word, sent MSB first
//   MAXERR  - consecutive mismatched words (1..15) that drop lock
//
// Ports:
//   CLK      in   1   clock, rising edge
//   n_RESET  in   1   asynchronous active-low reset
//   D        in   1   serial data bit
//   EN       in   1   bit strobe; D is sampled only when EN=1
//   Q        out  16  last complete word accepted at a word boundary
//   LOCKED   out  1   high while in LOCK
//   MATCH    out  1   one-cycle pulse: completed word equalled N
//   ERR      out  1   one-cycle pulse: word completed in LOCK and differed from N
//   ERRCNT   out  8   saturating ERR count (0 when the feature is disabled)
// ---------------------------------------------------------------------------
module pattern_rx #(
  parameter logic [15:0] N      = 16'b1010110011100001,
  parameter int          MAXERR = 3
) (
  input  logic        CLK,
  input  logic        n_RESET,
  input  logic        D,
  input  logic        EN,
  output logic [15:0] Q,
  output logic        LOCKED,
  output logic        MATCH,
  output logic        ERR,
  output logic [7:0]  ERRCNT
);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  localparam logic [3:0] MAXERR_L = 4'(MAXERR);

  logic [0:0]  state;
  logic [15:0] sr;
  logic [4:0]  fill;
  logic [3:0]  bitcnt;
  logic [3:0]  miscnt;
  logic [15:0] q;
  logic        match;
  logic        err;

  logic [15:0] newWin;
  logic        fillDone;
  logic        wordDone;
  logic        errEvent;
  logic [3:0]  miscntInc;

  // The window including the bit being sampled this edge. fillDone is true
  // when the fill counter is already full or becomes full with this bit, so
  // the very first comparison happens on the 16th bit after reset.
  always_comb begin
    newWin    = {sr[14:0], D};
    fillDone  = (fill >= 5'd15);
    wordDone  = (state == LOCK) && (bitcnt == 4'd15);
    errEvent  = EN && wordDone && (newWin != N);
    miscntInc = miscnt + 4'd1;
  end

  // Main receiver state. MATCH/ERR default low every cycle so they are
  // single-cycle pulses; everything else holds while EN is low.
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      state  <= HUNT;
      sr     <= 16'h0000;
      fill   <= 5'd0;
      bitcnt <= 4'd0;
      miscnt <= 4'd0;
      q      <= 16'h0000;
      match  <= 1'b0;
      err    <= 1'b0;
    end else begin
      match <= 1'b0;
      err   <= 1'b0;
      if (EN) begin
        sr <= newWin;
        if (fill != 5'd16) begin
          fill <= fill + 5'd1;
        end
        case (state)
          HUNT: begin
            if (fillDone && (newWin == N)) begin
              state  <= LOCK;
              q      <= N;
              match  <= 1'b1;
              bitcnt <= 4'd0;
              miscnt <= 4'd0;
            end
          end
          LOCK: begin
            // bitcnt wraps 15->0 on the bit that completes a word
            bitcnt <= bitcnt + 4'd1;
            if (wordDone) begin
              q <= newWin;
              if (newWin == N) begin
                match  <= 1'b1;
                miscnt <= 4'd0;
              end else begin
                err <= 1'b1;
                if (miscntInc == MAXERR_L) begin
                  state  <= HUNT;
                  miscnt <= 4'd0;
                end else begin
                  miscnt <= miscntInc;
                end
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef PATTERN_RX_ERRCNT_EN
  logic [7:0] errcnt;

  // Counts on the same edge that raises ERR, so ERRCNT already includes a
  // word's error during its ERR pulse. Cleared only by reset.
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      errcnt <= 8'h00;
    end else if (errEvent && (errcnt != 8'hFF)) begin
      errcnt <= errcnt + 8'd1;
    end
  end

  assign ERRCNT = errcnt;
`else
  assign ERRCNT = 8'h00;
`endif

  assign Q      = q;
  assign LOCKED = (state == LOCK);
  assign MATCH  = match;
  assign ERR    = err;

endmodule

// File: tb/tb_pattern_rx.sv
// ---------------------------------------------------------------------------
// tb_pattern_rx
//
// Directed testbench for pattern_rx. The stimulus side pushes the expected
// pulse (kind, Q, LOCKED, ERRCNT) into a scoreboard queue right before the
// bit that should produce it; a monitor pops and compares on every MATCH/ERR
// pulse. Honours PATTERN_RX_ERRCNT_EN for the expected ERRCNT values.
// ---------------------------------------------------------------------------
module tb_pattern_rx;

  localparam logic [15:0] SYNC = 16'hACE1;

  logic        CLK;
  logic        n_RESET;
  logic        D;
  logic        EN;
  logic [15:0] Q;
  logic        LOCKED;
  logic        MATCH;
  logic        ERR;
  logic [7:0]  ERRCNT;

  typedef struct packed {
    logic        isMatch;
    logic [15:0] q;
    logic        locked;
    logic [7:0]  errcnt;
  } expT;

  expT        sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] expErrcnt = 8'h00;

  pattern_rx #(
    .N      (16'b1010110011100001),
    .MAXERR (3)
  ) dut (
    .CLK     (CLK),
    .n_RESET (n_RESET),
    .D       (D),
    .EN      (EN),
    .Q       (Q),
    .LOCKED  (LOCKED),
    .MATCH   (MATCH),
    .ERR     (ERR),
    .ERRCNT  (ERRCNT)
  );

  // Free-running clock, 10 time-unit period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Queue one expected pulse; ERR expectations also advance the model count.
  task automatic expectPulse(input logic isMatch, input logic [15:0] q,
                             input logic locked);
    expT e;
    if (!isMatch) begin
`ifdef PATTERN_RX_ERRCNT_EN
      if (expErrcnt != 8'hFF) expErrcnt = expErrcnt + 8'd1;
`endif
    end
    e.isMatch = isMatch;
    e.q       = q;
    e.locked  = locked;
    e.errcnt  = expErrcnt;
    sb.push_back(e);
  endtask

  // One sampled bit: EN is high across exactly one rising edge.
  task automatic sendBit(input logic b);
    D  = b;
    EN = 1'b1;
    @(posedge CLK);
    #1;
    EN = 1'b0;
    D  = 1'b0;
  endtask

  // Send w[n-1:0] MSB first. Optionally pause with EN low after pauseAfter
  // bits. expKind: 0 none, 1 MATCH, 2 ERR, queued just before the last bit
  // so that any earlier pulse shows up as unexpected.
  task automatic applyStimulus(input logic [15:0] w, input int n,
                               input int pauseAfter, input int pauseCycles,
                               input int expKind, input logic expLocked);
    logic [15:0] qBefore;
    logic        lockBefore;
    for (int i = n - 1; i >= 0; i--) begin
      if (i == 0 && expKind != 0) begin
        expectPulse(expKind == 1, w, expLocked);
      end
      sendBit(w[i]);
      if ((n - i) == pauseAfter) begin
        qBefore    = Q;
        lockBefore = LOCKED;
        repeat (pauseCycles) @(posedge CLK);
        #1;
        checkOutput("pauseQ", Q, qBefore);
        checkOutput("pauseLocked", LOCKED, lockBefore);
        checkOutput("pauseMatch", MATCH, 1'b0);
      end
    end
  endtask

  // The expected pulse must have been seen at the first negedge after the
  // completing edge.
  task automatic checkDrained(input string name);
    @(negedge CLK);
    #1;
    checkOutput(name, sb.size(), 0);
  endtask

  // Monitor: every MATCH/ERR pulse must correspond to a queued expectation.
  always @(negedge CLK) begin
    expT e;
    if (MATCH || ERR) begin
      if (MATCH && ERR) begin
        checkOutput("pulseExclusive", {MATCH, ERR}, 2'b10);
      end
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedPulse: got MATCH=%0b ERR=%0b Q=%0h expected no pulse at %0t",
                 MATCH, ERR, Q, $time);
      end else begin
        e = sb.pop_front();
        checkOutput("pulseKind", MATCH, e.isMatch);
        checkOutput("pulseQ", Q, e.q);
        checkOutput("pulseLocked", LOCKED, e.locked);
        checkOutput("pulseErrcnt", ERRCNT, e.errcnt);
      end
    end
  end

  // Guard against a hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_RESET = 1'b0;
    D       = 1'b0;
    EN      = 1'b1;
    #12;
    checkOutput("resetQ", Q, 16'h0000);
    checkOutput("resetLocked", LOCKED, 1'b0);
    checkOutput("resetMatch", MATCH, 1'b0);
    checkOutput("resetErr", ERR, 1'b0);
    checkOutput("resetErrcnt", ERRCNT, 8'h00);
    @(negedge CLK);
    n_RESET = 1'b1;

    // First lock from reset.
    applyStimulus(SYNC, 16, -1, 0, 1, 1'b1);
    checkDrained("firstLock");
    checkOutput("firstLockLocked", LOCKED, 1'b1);

    // Locked word with a 5-cycle EN gap mid-word.
    applyStimulus(SYNC, 16, 8, 5, 1, 1'b1);
    checkDrained("pausedWord");
    checkOutput("pausedLocked", LOCKED, 1'b1);

    // Three bad words drop lock on the third.
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(16'h0000, 16, -1, 0, 2, (k < 3));
      checkDrained("badWord");
    end
    checkOutput("dropLocked", LOCKED, 1'b0);
    checkOutput("dropQ", Q, 16'h0000);
    checkOutput("dropErrcnt", ERRCNT, expErrcnt);

    // Hunt: three arbitrary bits, then the sync word.
    applyStimulus(16'h0006, 3, -1, 0, 0, 1'b0);
    applyStimulus(SYNC, 16, -1, 0, 1, 1'b1);
    checkDrained("relock");

    // Reset after 7 bits of a locked word.
    applyStimulus(SYNC >> 9, 7, -1, 0, 0, 1'b1);
    #3;
    n_RESET   = 1'b0;
    expErrcnt = 8'h00;
    #1;
    checkOutput("asyncQ", Q, 16'h0000);
    checkOutput("asyncLocked", LOCKED, 1'b0);
    checkOutput("asyncErrcnt", ERRCNT, 8'h00);
    @(negedge CLK);
    n_RESET = 1'b1;
    // The rest of the interrupted word must not complete anything.
    applyStimulus(SYNC, 9, -1, 0, 0, 1'b0);
    checkOutput("partialLocked", LOCKED, 1'b0);
    applyStimulus(SYNC, 16, -1, 0, 1, 1'b1);
    checkDrained("lockAfterReset");

`ifdef PATTERN_RX_ERRCNT_EN
    // 300 bad words with relocks in between saturate the error count.
    for (int r = 0; r < 100; r++) begin
      for (int k = 1; k <= 3; k++) begin
        applyStimulus(16'h0000, 16, -1, 0, 2, (k < 3));
      end
      applyStimulus(SYNC, 16, -1, 0, 1, 1'b1);
    end
    checkDrained("saturateDrained");
    checkOutput("errcntSaturated", ERRCNT, 8'hFF);
`endif

    checkDrained("finalDrained");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
